alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Time-shares one combinational ALU instance (add/sub, WIDTH bits, carry/overflow outputs) between NUM_REQ requesters.
- Round-robin arbitration selects one request at a time and registers its operands onto the ALU inputs.
- Captures the ALU result and returns it on a single valid/ready response channel, tagged with the requester ID.
- Sits between the ALU instance and its client logic (address generators, DMA length/offset math).

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 8, operand and result width; must match the attached ALU.
- ID_WIDTH, 2, width of respId; equals ceil(log2(NUM_REQ)), minimum 1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- reqValid  input  NUM_REQ  per-requester request valid.
- reqReady  output  NUM_REQ  per-requester accept strobe.
- reqAddMode  input  NUM_REQ  per-requester operation: 1 = A+B, 0 = A-B.
- reqOperandA  input  NUM_REQ*WIDTH  packed operand A; requester k uses bits [k*WIDTH +: WIDTH].
- reqOperandB  input  NUM_REQ*WIDTH  packed operand B, same packing.
- respValid  output  1  response available.
- respReady  input  1  consumer accepts response.
- respId  output  ID_WIDTH  index of the requester that owns the response.
- respResult  output  WIDTH  ALU result.
- respCarry  output  1  ALU carry; for subtraction, 1 = no borrow (A >= B unsigned).
- respOverflow  output  1  ALU signed overflow.
- aluAddMode  output  1  registered mode driven to the ALU.
- aluOperandA  output  WIDTH  registered operand A driven to the ALU.
- aluOperandB  output  WIDTH  registered operand B driven to the ALU.
- aluResult  input  WIDTH  ALU result, combinational from the alu* outputs.
- aluCarry  input  1  ALU carry out.
- aluOverflow  input  1  ALU overflow out.

Behaviour:
- FSM states:
  - IDLE: reqReady[g] = 1 combinationally for the granted requester g only, when any reqValid is set. Handshake when reqValid[g] & reqReady[g]. On the handshake edge: latch mode and operands into the alu* registers, latch g into respId and the last-grant pointer, go to EXEC. If no reqValid is set, stay in IDLE.
  - EXEC: reqReady = 0. One settle cycle for the ALU carry chain. On the exit edge: capture aluResult, aluCarry and aluOverflow into the resp* registers, set respValid = 1, go to RESP.
  - RESP: reqReady = 0. All resp* outputs and alu* registers are held stable. On respValid & respReady: respValid = 0, go to IDLE.
- Latency: accept edge at cycle T -> respValid high from T+2. Best-case throughput is 1 op per 3 cycles; a new accept happens no earlier than the cycle after the response handshake.
- Arbitration: round-robin search starting at (lastGrant+1) mod NUM_REQ. After reset lastGrant = NUM_REQ-1, so requester 0 has first priority. A lone requester is granted back-to-back.
- A requester must hold reqValid, mode and operands stable until accepted. Dropping reqValid before accept is a protocol violation; behaviour is unspecified but the FSM must not hang.
- Arithmetic: the block does no arithmetic. Result, carry and overflow pass through unchanged and wrap modulo 2^WIDTH.
- Reset (valid in any state, including mid-operation):
  - state = IDLE; respValid = 0; reqReady = 0 during reset.
  - respId, respResult, respCarry, respOverflow = 0.
  - aluAddMode, aluOperandA, aluOperandB = 0; lastGrant = NUM_REQ-1.
  - An in-flight operation is discarded and never responded to.
- Simultaneous events: a reqValid that rises during EXEC or RESP waits. Its arbitration uses the pointer value at the IDLE cycle.

Test Plan:
- Reset: hold reset 2 cycles with reqValid = 4'hF -> reqReady = 0, respValid = 0, all resp*/alu* = 0. On the first IDLE cycle after release, reqReady = 4'b0001.
- Single add: req1 A=8'h7F, B=8'h01, addMode=1, accepted at T -> respValid at T+2 with respId=1, respResult=8'h80, respCarry=0, respOverflow=1. respReady=1 -> respValid=0 at T+3.
- Subtract with borrow: req2 A=8'h10, B=8'h20, addMode=0 -> respResult=8'hF0, carry=0, overflow=0. Then A=8'h20, B=8'h10 -> 8'h10, carry=1, overflow=0.
- Round-robin fairness: reqValid=4'hF held, respReady=1 -> grant order 0,1,2,3,0,1. Accepts spaced exactly 3 cycles apart.
- Backpressure: respReady=0 for 5 cycles in RESP -> respValid stays 1, resp* stable, reqReady=0 throughout. The response completes on the cycle respReady rises.
- Reset mid-RESP: assert reset while respValid=1 with respId=3 -> respValid=0 the next cycle. After release with reqValid=4'hF, requester 0 is granted first.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin front end that time-shares one combinational add/sub ALU between
// NUM_REQ requesters and returns tagged results on a single valid/ready channel.
module alu_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int WIDTH    = 8,
    parameter int ID_WIDTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         reqValid,
    output logic [NUM_REQ-1:0]         reqReady,
    input  logic [NUM_REQ-1:0]         reqAddMode,
    input  logic [NUM_REQ*WIDTH-1:0]   reqOperandA,
    input  logic [NUM_REQ*WIDTH-1:0]   reqOperandB,
    output logic                       respValid,
    input  logic                       respReady,
    output logic [ID_WIDTH-1:0]        respId,
    output logic [WIDTH-1:0]           respResult,
    output logic                       respCarry,
    output logic                       respOverflow,
    output logic                       aluAddMode,
    output logic [WIDTH-1:0]           aluOperandA,
    output logic [WIDTH-1:0]           aluOperandB,
    input  logic [WIDTH-1:0]           aluResult,
    input  logic                       aluCarry,
    input  logic                       aluOverflow
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t              state;
    logic [ID_WIDTH-1:0] last_grant;
    logic [ID_WIDTH-1:0] grant_idx;
    logic [ID_WIDTH-1:0] cand_idx;
    logic                grant_found;
    int                  cand;

    // Search starts one past the previous winner so every requester gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = int'(last_grant) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            cand_idx = ID_WIDTH'(cand);
            if (!grant_found && reqValid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        reqReady = '0;
        if (state == IDLE && !reset && grant_found) reqReady[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            respValid    <= 1'b0;
            respId       <= '0;
            respResult   <= '0;
            respCarry    <= 1'b0;
            respOverflow <= 1'b0;
            aluAddMode   <= 1'b0;
            aluOperandA  <= '0;
            aluOperandB  <= '0;
            last_grant   <= ID_WIDTH'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        aluAddMode  <= reqAddMode[grant_idx];
                        aluOperandA <= reqOperandA[grant_idx*WIDTH +: WIDTH];
                        aluOperandB <= reqOperandB[grant_idx*WIDTH +: WIDTH];
                        respId      <= grant_idx;
                        last_grant  <= grant_idx;
                        state       <= EXEC;
                    end
                end
                // Operands have been on the ALU for a full cycle; carry chain has settled.
                EXEC: begin
                    respResult   <= aluResult;
                    respCarry    <= aluCarry;
                    respOverflow <= aluOverflow;
                    respValid    <= 1'b1;
                    state        <= RESP;
                end
                RESP: begin
                    if (respReady) begin
                        respValid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
